fetchnum: RTL and testbench
===========================

# fetchnum

Group-fetch unit for the BNN-VAD datapath. It presents a fixed 20-word input buffer as four consecutive 5-word groups. Each enabled cycle it loads the next group onto a registered output bus. It raises `empty` once all groups have been issued. It sits between the feature buffer and the 5-input compute stage, which consumes one group per fetch.

## Interface
- `DATA_W`, default 16: width of one word.
- `TOTAL`, default 20: number of words in the input buffer.
- `GROUP`, default 5: words per fetch. `TOTAL` must be an integer multiple of `GROUP`.
- `clk`, in, 1: the single clock; all logic is rising-edge triggered.
- `rst_n`, in, 1: synchronous, active-high reset (asserted = 1). The port name follows the codebase; the polarity and synchronicity are fixed.
- `read_en`, in, 1: fetch request, sampled every rising edge.
- `data_in`, in, TOTAL*DATA_W: flattened buffer. Word k (1-based) occupies bits [k*DATA_W-1 : (k-1)*DATA_W].
- `data_one`, out, GROUP*DATA_W: current group, registered. Slot j (1-based) occupies bits [j*DATA_W-1 : (j-1)*DATA_W].
- `empty`, out, 1: registered flag, high once all TOTAL/GROUP groups have been issued.

## Operation
- Internal group pointer `ptr` ranges over 0 .. NG, where NG = TOTAL/GROUP (4 by default). Width is clog2(NG+1).
- Reset (`rst_n`=1 at an edge) has priority over everything. It sets `ptr`=0, `data_one`=0 and `empty`=0.
- Fetch: if `read_en`=1 and `empty`=0 at an edge:
  - slot j of `data_one` is loaded with word GROUP*ptr + j of `data_in`;
  - `ptr` increments by 1;
  - `empty` is set if the new `ptr` equals NG.
- If `read_en`=0, or `empty`=1: `ptr`, `data_one` and `empty` hold their values.
- `read_en` while `empty` is high is ignored; there is no wrap-around.
- `empty` stays high until reset. Reset is the only way to restart from group 0.
- `data_in` is read live at the fetch edge and is not latched. Changes to words of groups already issued have no effect. Changes to words of pending groups are picked up at their fetch.
- No arithmetic is performed; words pass through unchanged.

## Timing
- Latency: one cycle. The group selected by `ptr` at edge N is visible on `data_one` after edge N.
- A continuous `read_en` issues one group per cycle with no bubbles.
- `empty` rises on the same edge that loads the last group. The last group remains on `data_one` while `empty`=1.
- Reset asserted mid-sequence: on that edge the outputs go to their reset values regardless of `read_en`.
- `read_en` on the first edge after reset is released: the fetch occurs on that edge.

## Structure
- The constants DATA_W, TOTAL, GROUP and NG = TOTAL/GROUP belong in a shared package, `vad_pkg`, for reuse by the producer and consumer stages.
- Group selection is a natural sub-module, `group_mux`. It is combinational, with inputs `data_in` and `ptr` and output the GROUP*DATA_W slice.
- The top level holds the `ptr` register, the `data_one` register and the `empty` register.

## Test plan
- Reset: hold `rst_n`=1 for 1 cycle -> `data_one`=0, `empty`=0.
- Burst: `data_in` = words 1..20, `read_en` held for 10 cycles. `data_one` must be:
  - {1,2,3,4,5} after the 1st edge;
  - {6..10} after the 2nd edge;
  - {11..15} after the 3rd edge;
  - {16..20} after the 4th edge, with `empty`=1 on that same edge.
  - The remaining 6 cycles leave `data_one`={16..20}.
- Gapped requests: pulse `read_en` on alternate cycles -> groups advance only on enabled edges, and outputs hold in between.
- Mid-sequence reset: assert reset after 2 groups -> `data_one`=0, `empty`=0. The next fetch returns {1..5}.
- Live input: after the first fetch, change word 7 to 99 -> the second fetch returns {6,99,8,9,10}. Changing word 2 afterwards has no effect on `data_one`.
- Post-empty: with `empty`=1, `read_en`=1 for 5 cycles -> no change to any output.

Source files
------------

// File: rtl/vad_pkg.sv
// Shared BNN-VAD word and group geometry, used by the feature buffer, the fetch unit and the compute stage.
// Pointer width is derived here so that every stage sizes its group counter the same way.
package vad_pkg;

  localparam int DATA_W = 16;
  localparam int TOTAL  = 20;
  localparam int GROUP  = 5;
  localparam int NG     = TOTAL / GROUP;

  // A pointer must also hold the value NG, which marks "all groups issued".
  function automatic int ptr_width(input int num_groups);
    ptr_width = (num_groups < 1) ? 1 : $clog2(num_groups + 1);
  endfunction

  localparam int PTR_W = ptr_width(NG);

endpackage

// File: rtl/group_mux.sv
// Combinational group select: returns words GROUP*ptr+1 .. GROUP*ptr+GROUP of data_in.
// Zero latency and no flow control; an out-of-range pointer (ptr == NG) selects all zeros.
module group_mux
  import vad_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int TOTAL_P  = TOTAL,
  parameter int GROUP_P  = GROUP,
  parameter int PTR_W_P  = ptr_width(TOTAL_P / GROUP_P)
) (
  input  logic [TOTAL_P*DATA_W_P-1:0] data_in,
  input  logic [PTR_W_P-1:0]          ptr,
  output logic [GROUP_P*DATA_W_P-1:0] data_out
);

  localparam int NG_P = TOTAL_P / GROUP_P;
  localparam int GW   = GROUP_P * DATA_W_P;

  logic [GW-1:0] w_slice;

  always_comb begin
    w_slice = '0;
    for (int g = 0; g < NG_P; g++) begin
      if (ptr == PTR_W_P'(g)) begin
        w_slice = data_in[g*GW +: GW];
      end
    end
  end

  assign data_out = w_slice;

endmodule

// File: rtl/fetchnum.sv
// Group-fetch unit: issues the input buffer as TOTAL/GROUP consecutive groups, one per read_en cycle, registered (1-cycle latency).
// No backpressure beyond read_en; requests after the last group are ignored and empty holds until reset.
module fetchnum
  import vad_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int TOTAL_P  = TOTAL,
  parameter int GROUP_P  = GROUP
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        read_en,
  input  logic [TOTAL_P*DATA_W_P-1:0] data_in,
  output logic [GROUP_P*DATA_W_P-1:0] data_one,
  output logic                        empty
);

  localparam int NG_P    = TOTAL_P / GROUP_P;
  localparam int PTR_W_P = ptr_width(NG_P);
  localparam int GW      = GROUP_P * DATA_W_P;

  logic [PTR_W_P-1:0] r_ptr;
  logic [GW-1:0]      r_data_one;
  logic               r_empty;

  logic               w_fetch;
  logic [PTR_W_P-1:0] w_ptr_nxt;
  logic [GW-1:0]      w_group;

  group_mux #(
    .DATA_W_P (DATA_W_P),
    .TOTAL_P  (TOTAL_P),
    .GROUP_P  (GROUP_P),
    .PTR_W_P  (PTR_W_P)
  ) u_group_mux (
    .data_in  (data_in),
    .ptr      (r_ptr),
    .data_out (w_group)
  );

  assign w_fetch   = read_en && !r_empty;
  assign w_ptr_nxt = r_ptr + PTR_W_P'(1);

  // rst_n is active-high despite its name; it matches the upstream port naming.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ptr      <= '0;
      r_data_one <= '0;
      r_empty    <= 1'b0;
    end else if (w_fetch) begin
      r_ptr      <= w_ptr_nxt;
      r_data_one <= w_group;
      r_empty    <= (w_ptr_nxt == PTR_W_P'(NG_P));
    end
  end

  assign data_one = r_data_one;
  assign empty    = r_empty;

endmodule

// File: tb/tb_fetchnum.sv
// Directed bench for fetchnum: reset, burst, gapped reads, mid-sequence reset, live input and post-empty hold.
module tb_fetchnum;

  localparam int DW = 16;
  localparam int TW = 20 * DW;
  localparam int GW = 5 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          read_en;
  logic [TW-1:0] data_in;
  logic [GW-1:0] data_one;
  logic          empty;

  int n_vec = 0;
  int n_err = 0;

  fetchnum dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_one (data_one),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input int v);
    data_in[(k-1)*DW +: DW] = DW'(v);
  endtask

  task automatic load_ramp();
    for (int k = 1; k <= 20; k++) set_word(k, k);
  endtask

  function automatic logic [GW-1:0] grp(input int a, input int b, input int c,
                                        input int d, input int e);
    grp = {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input logic exp);
    n_vec++;
    assert (empty === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, empty, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    read_en = 1'b0;
    data_in = '0;
    load_ramp();

    // Reset state
    tick();
    chk("reset_data", data_one, '0);
    chk_e("reset_empty", 1'b0);

    // Burst of 10 enabled cycles
    rst_n   = 1'b0;
    read_en = 1'b1;
    tick();
    chk("burst_g1", data_one, grp(1, 2, 3, 4, 5));
    chk_e("burst_g1_empty", 1'b0);
    tick();
    chk("burst_g2", data_one, grp(6, 7, 8, 9, 10));
    tick();
    chk("burst_g3", data_one, grp(11, 12, 13, 14, 15));
    chk_e("burst_g3_empty", 1'b0);
    tick();
    chk("burst_g4", data_one, grp(16, 17, 18, 19, 20));
    chk_e("burst_g4_empty", 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("burst_tail", data_one, grp(16, 17, 18, 19, 20));
    end

    // Post-empty: further requests and input changes are ignored
    for (int k = 1; k <= 20; k++) set_word(k, 200 + k);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_empty_data", data_one, grp(16, 17, 18, 19, 20));
      chk_e("post_empty_flag", 1'b1);
    end

    // Reset out of the empty state, with read_en still high
    load_ramp();
    rst_n = 1'b1;
    tick();
    chk("reset2_data", data_one, '0);
    chk_e("reset2_empty", 1'b0);

    // Gapped requests
    rst_n = 1'b0;
    read_en = 1'b1;
    tick();
    chk("gap_g1", data_one, grp(1, 2, 3, 4, 5));
    read_en = 1'b0;
    tick();
    chk("gap_hold1", data_one, grp(1, 2, 3, 4, 5));
    read_en = 1'b1;
    tick();
    chk("gap_g2", data_one, grp(6, 7, 8, 9, 10));
    read_en = 1'b0;
    tick();
    chk("gap_hold2", data_one, grp(6, 7, 8, 9, 10));
    chk_e("gap_empty", 1'b0);

    // Mid-sequence reset after two groups
    rst_n   = 1'b1;
    read_en = 1'b1;
    tick();
    chk("mid_reset_data", data_one, '0);
    chk_e("mid_reset_empty", 1'b0);
    rst_n = 1'b0;
    tick();
    chk("restart_g1", data_one, grp(1, 2, 3, 4, 5));

    // Live input: pending word change is picked up, issued word change is not
    set_word(7, 99);
    tick();
    chk("live_g2", data_one, grp(6, 99, 8, 9, 10));
    set_word(2, 77);
    read_en = 1'b0;
    tick();
    chk("live_hold", data_one, grp(6, 99, 8, 9, 10));
    read_en = 1'b1;
    tick();
    chk("live_g3", data_one, grp(11, 12, 13, 14, 15));
    chk_e("live_g3_empty", 1'b0);
    tick();
    chk("live_g4", data_one, grp(16, 17, 18, 19, 20));
    chk_e("live_g4_empty", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
